// File: rtl/vga_crossfade_mixer.sv
// VGA raster generator with a two-source alpha blender and a frame-synchronous fade engine.
// Colour, sync and DE outputs share a two-stage pipeline behind the raster counters.
module vga_crossfade_mixer #(
  parameter int CW      = 10,
  parameter int AW      = 3,
  parameter int XW      = 12,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter int FPS     = 4
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [CW-1:0] iRed_1,
  input  logic [CW-1:0] iGreen_1,
  input  logic [CW-1:0] iBlue_1,
  input  logic [CW-1:0] iRed_2,
  input  logic [CW-1:0] iGreen_2,
  input  logic [CW-1:0] iBlue_2,
  input  logic          iStart,
  input  logic          iDir,
  input  logic          iBypass,
  output logic [XW-1:0] now_x,
  output logic [XW-1:0] now_y,
  output logic          oHS,
  output logic          oVS,
  output logic          oDE,
  output logic [CW-1:0] oRed,
  output logic [CW-1:0] oGreen,
  output logic [CW-1:0] oBlue,
  output logic [AW:0]   oAlpha,
  output logic          oBusy,
  output logic          oDone
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int X_START = H_SYNC + H_BACK;
  localparam int Y_START = V_SYNC + V_BACK;
  localparam int M       = 1 << AW;
  localparam int PW      = CW + AW + 1;
  localparam int FW      = (FPS > 1) ? $clog2(FPS) : 1;

  localparam logic [XW-1:0] X_ZERO     = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE      = XW'(1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] V_LAST     = XW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_SYNC);
  localparam logic [XW-1:0] V_SYNC_END = XW'(V_SYNC);
  localparam logic [XW-1:0] X_BEGIN    = XW'(X_START);
  localparam logic [XW-1:0] X_END      = XW'(X_START + H_ACT);
  localparam logic [XW-1:0] Y_BEGIN    = XW'(Y_START);
  localparam logic [XW-1:0] Y_END      = XW'(Y_START + V_ACT);

  localparam logic [AW:0]   ALPHA_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   ALPHA_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   ALPHA_M    = (AW+1)'(M);
  localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FPS - 1);
  localparam logic [PW-1:0] PROD_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] ROUND_HALF = PW'(M / 2);
  localparam logic [CW-1:0] PIX_ZERO   = {CW{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------- raster
  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [XW-1:0] v_cnt_q, v_cnt_d;
  logic          h_end_s, v_end_s, sof_s;
  logic          hs_raw_s, vs_raw_s, de_raw_s;

  // Raster counter registers
  always_ff @(posedge iclk) begin
    if (irst) begin
      h_cnt_q <= X_ZERO;
      v_cnt_q <= X_ZERO;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Counter wrap, raw sync/DE decode and start-of-frame strobe
  always_comb begin
    h_end_s  = (h_cnt_q == H_LAST);
    v_end_s  = (v_cnt_q == V_LAST);
    sof_s    = h_end_s & v_end_s;
    h_cnt_d  = h_end_s ? X_ZERO : (h_cnt_q + X_ONE);
    v_cnt_d  = h_end_s ? (v_end_s ? X_ZERO : (v_cnt_q + X_ONE)) : v_cnt_q;
    hs_raw_s = ~(h_cnt_q < H_SYNC_END);
    vs_raw_s = ~(v_cnt_q < V_SYNC_END);
    de_raw_s = (h_cnt_q >= X_BEGIN) && (h_cnt_q < X_END) &&
               (v_cnt_q >= Y_BEGIN) && (v_cnt_q < Y_END);
  end

  assign now_x = h_cnt_q - X_BEGIN;
  assign now_y = v_cnt_q - Y_BEGIN;

  // ---------------------------------------------------------------- fade engine
  state_t        state_q, state_d;
  logic [AW:0]   alpha_q, alpha_d;
  logic [AW:0]   target_q, target_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Fade state and registered status outputs
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      alpha_q     <= ALPHA_ZERO;
      target_q    <= ALPHA_ZERO;
      frame_cnt_q <= FRAME_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alpha_q     <= alpha_d;
      target_q    <= target_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state decode; a start during RUN is deliberately ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sof_s && (alpha_q == target_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Alpha stepping, frame pacing and completion pulse; alpha moves only at sof
  always_comb begin
    alpha_d     = alpha_q;
    target_d    = target_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    busy_d      = (state_d == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          target_d    = iDir ? ALPHA_ZERO : ALPHA_M;
          frame_cnt_d = FRAME_ZERO;
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      ST_RUN: begin
        if (!sof_s) begin
          frame_cnt_d = frame_cnt_q;
        end else if (alpha_q == target_q) begin
          done_d = 1'b1;
        end else if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = FRAME_ZERO;
          alpha_d     = (alpha_q < target_q) ? (alpha_q + ALPHA_ONE) : (alpha_q - ALPHA_ONE);
        end else begin
          frame_cnt_d = frame_cnt_q + FRAME_ONE;
        end
      end
      default: begin
        alpha_d = ALPHA_ZERO;
      end
    endcase
  end

  assign oAlpha = alpha_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

  // ---------------------------------------------------------------- blend pipeline
  logic [CW-1:0] c1_s [3];
  logic [CW-1:0] c2_s [3];
  logic [AW:0]   a_eff_s, a_inv_s;
  logic [PW-1:0] prod1_d [3];
  logic [PW-1:0] prod2_d [3];
  logic [PW-1:0] prod1_q [3];
  logic [PW-1:0] prod2_q [3];
  logic [PW-1:0] sum_s [3];
  logic [CW-1:0] pix_d [3];
  logic [CW-1:0] pix_q [3];
  logic          hs1_q, vs1_q, de1_q;
  logic          hs2_q, vs2_q, de2_q;
  logic          unused_sum_s;

  // Stage 0: weighted products; bypass uses weight 0 so the sum reduces to c1 exactly
  always_comb begin
    c1_s[0] = iRed_1;
    c1_s[1] = iGreen_1;
    c1_s[2] = iBlue_1;
    c2_s[0] = iRed_2;
    c2_s[1] = iGreen_2;
    c2_s[2] = iBlue_2;
    a_eff_s = iBypass ? ALPHA_ZERO : alpha_q;
    a_inv_s = ALPHA_M - a_eff_s;
    for (int ch = 0; ch < 3; ch++) begin
      prod1_d[ch] = PW'(c1_s[ch]) * PW'(a_inv_s);
      prod2_d[ch] = PW'(c2_s[ch]) * PW'(a_eff_s);
    end
  end

  // Stage 1 registers: products plus raw timing; syncs idle high after reset
  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int ch = 0; ch < 3; ch++) begin
        prod1_q[ch] <= PROD_ZERO;
        prod2_q[ch] <= PROD_ZERO;
      end
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      de1_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        prod1_q[ch] <= prod1_d[ch];
        prod2_q[ch] <= prod2_d[ch];
      end
      hs1_q <= hs_raw_s;
      vs1_q <= vs_raw_s;
      de1_q <= de_raw_s;
    end
  end

  // Stage 2 combinational: rounded sum, shift and blanking mask
  always_comb begin
    unused_sum_s = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      sum_s[ch]    = prod1_q[ch] + prod2_q[ch] + ROUND_HALF;
      pix_d[ch]    = de1_q ? sum_s[ch][AW +: CW] : PIX_ZERO;
      unused_sum_s = unused_sum_s ^ sum_s[ch][PW-1] ^ (^sum_s[ch][AW-1:0]);
    end
  end

  // Stage 2 registers: final colour and aligned timing
  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int ch = 0; ch < 3; ch++) begin
        pix_q[ch] <= PIX_ZERO;
      end
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      de2_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        pix_q[ch] <= pix_d[ch];
      end
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

  assign oRed   = pix_q[0];
  assign oGreen = pix_q[1];
  assign oBlue  = pix_q[2];
  assign oHS    = hs2_q;
  assign oVS    = vs2_q;
  assign oDE    = de2_q;

endmodule

// File: doc/vga_crossfade_mixer.md
# vga_crossfade_mixer

Parametrised successor to the two-source VGA signal combiner. Generates VGA raster timing from parameters and blends two RGB pixel sources with an alpha weight. A frame-synchronous fade engine ramps the weight automatically and raises a done pulse when the fade completes. Sits between the two pixel sources (camera/filter paths) and the VGA DAC.

## Interface
Parameters:
- CW, 10, colour channel width
- AW, 3, alpha resolution; full scale M = 2^AW
- XW, 12, counter and coordinate width
- H_SYNC/H_BACK/H_ACT/H_FRONT, 96/48/640/16, horizontal timing in clocks
- V_SYNC/V_BACK/V_ACT/V_FRONT, 2/33/480/10, vertical timing in lines
- FPS, 4, frames per alpha step (≥1)

Ports:
- iclk  in  1  pixel clock
- irst  in  1  synchronous reset, active-high
- iRed_1/iGreen_1/iBlue_1  in  CW each  source 1 pixel for now_x/now_y
- iRed_2/iGreen_2/iBlue_2  in  CW each  source 2 pixel for now_x/now_y
- iStart  in  1  single-cycle fade request
- iDir  in  1  sampled with iStart: 0 fades toward source 2 (target M), 1 toward source 1 (target 0)
- iBypass  in  1  force source 1 at output; engine keeps running
- now_x, now_y  out  XW  raster coordinate, H_Cont−X_START / V_Cont−Y_START modulo 2^XW
- oHS, oVS, oDE  out  1  syncs (active-low) and data enable, pipeline-aligned
- oRed/oGreen/oBlue  out  CW  blended pixel, 0 outside DE
- oAlpha  out  AW+1  current weight, 0..M
- oBusy  out  1  fade in progress
- oDone  out  1  one-cycle completion pulse

## Operation
- Counters: H_Cont 0..H_TOTAL−1 (H_TOTAL = sum of H params), V_Cont 0..V_TOTAL−1, V increments when H wraps. X_START = H_SYNC+H_BACK, Y_START = V_SYNC+V_BACK.
- Raw HS low for H_Cont < H_SYNC; VS low for V_Cont < V_SYNC; DE when H_Cont in [X_START, X_START+H_ACT) and V_Cont in [Y_START, Y_START+V_ACT).
- sof: the cycle with H_Cont = H_TOTAL−1 and V_Cont = V_TOTAL−1.
- Blend per channel: out = (c1·(M−a) + c2·a + M/2) >> AW, computed at CW+AW+1 bits and exact; a = M yields c2 and a = 0 yields c1. With iBypass = 1, out = c1.
- FSM IDLE/RUN:
  - IDLE: on iStart, latch target (M or 0), clear frame_cnt, go to RUN and assert oBusy.
  - RUN, at each sof: if alpha equals the target, pulse oDone, drop oBusy and return to IDLE. Otherwise, if frame_cnt = FPS−1, clear frame_cnt and step alpha ±1 toward the target; else increment frame_cnt.
- Alpha changes only at sof, so the new value applies from pixel (0,0) onward and no frame tears.
- An iStart during RUN is ignored. An iStart coincident with sof is accepted, but that sof is not counted.
- An iStart with alpha already at the target completes at the next sof with alpha unchanged.

## Timing
- Cycle 0: counters produce now_x/now_y and the sources present pixels combinationally in the same cycle.
- Stage 1 registers the products. Stage 2 registers the sum/shift plus DE masking.
- HS/VS/DE are delayed by the same 2 cycles, so colour output lags now_x by exactly 2 clocks.
- oBusy, oAlpha and oDone are registered. oDone is high in the cycle after the terminal sof, and oBusy falls in the same cycle.
- Reset (any cycle, including mid-fade) forces in the next cycle:
  - counters = 0, alpha = 0, frame_cnt = 0, state IDLE
  - oBusy = 0, oDone = 0, oAlpha = 0, pipeline colours = 0, oDE = 0
  - oHS and oVS take their raw values for counter = 0 after the pipeline refills; they read 1 (inactive) while the pipeline is cleared.
- Full fade 0→M at defaults: alpha steps at sofs 4, 8, …, 32 after start. oDone follows sof 33.

## Test plan
- Raster check: run 2 frames at defaults. Require 800 clocks per line and 525 lines per frame, HS low for 96 clocks, VS low for 2 lines, and 640×480 DE clocks per frame.
- Blend arithmetic: force alpha = 4 (M = 8) with c1 = 1023 and c2 = 0. Require an output of 512 exactly 2 clocks after the matching now_x. Require 0 whenever DE is low.
- Fade sequence: iStart with iDir = 0 from alpha 0. Require oAlpha = 1 after sof 4 and 8 after sof 32. Require oDone for 1 cycle after sof 33, and oBusy high throughout until that cycle.
- Edge starts: iStart during RUN, with a reverse iDir, must be ignored. iStart with iDir = 1 at alpha 0 must give oDone after the next sof with alpha still 0. iStart on the sof cycle must give its first step at the 4th following sof.
- Bypass: iBypass = 1 mid-fade with c1 = 100 and c2 = 900 must output 100 while oAlpha keeps stepping.
- Reset mid-fade: assert irst at alpha 5. Next cycle require oAlpha = 0, oBusy = 0, counters at 0 and colours 0. A subsequent fade must complete normally.
